speck_round_sequencer: RTL

Iterative SPECK128/128 encryption controller. It owns one combinational round/key-expansion datapath and steps it through all 32 rounds. Round keys are generated on the fly, one per round. It replaces the chain of separately instantiated round and key_schedule units with one time-multiplexed engine. The surrounding system drives it through a start/finished handshake.

---
 rtl/speck_pkg.sv | 39 +++
 rtl/speck_round_sequencer_if.sv | 42 ++++
 rtl/speck_round.sv | 39 +++
 rtl/speck_round_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared constants and types for the iterative SPECK128/128 encryption engine.
//
// Contents:
//   WORD_W   - SPECK word width (64 for SPECK128)
//   ROUNDS   - number of rounds for a 128-bit key (32)
//   ALPHA    - right-rotate amount applied to x and l
//   BETA     - left-rotate amount applied to y and k
//   CNT_W    - width of the round counter
//   word_t   - one 64-bit SPECK word
//   block_t  - a 128-bit block or key ({hi word, lo word})
//   state_t  - sequencer state (IDLE, RUN, DONE)
//   ror_alpha / rol_beta - fixed-amount rotate helpers
package speck_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned ROUNDS = 32;
   localparam int unsigned ALPHA  = 8;
   localparam int unsigned BETA   = 3;
   localparam int unsigned CNT_W  = $clog2(ROUNDS);

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [2*WORD_W-1:0] block_t;
   typedef logic [CNT_W-1:0]    cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic word_t ror_alpha(input word_t v);
      return (v >> ALPHA) | (v << (WORD_W - ALPHA));
   endfunction

   function automatic word_t rol_beta(input word_t v);
      return (v << BETA) | (v >> (WORD_W - BETA));
   endfunction

endpackage

// File: rtl/speck_round_sequencer_if.sv
// Start/finished handshake bundle for speck_round_sequencer.
//
// Signals:
//   start      - request one encryption (sampled only while the engine is idle)
//   key        - cipher key, [127:64] = l0, [63:0] = k0
//   plaintext  - input block, [127:64] = x, [63:0] = y
//   ciphertext - result block, held until the next completion or reset
//   busy       - an encryption is in progress
//   finished   - one-cycle pulse when ciphertext becomes valid
//
// Modports:
//   master - the requesting system (drives start/key/plaintext)
//   slave  - the encryption engine
interface speck_round_sequencer_if;
   import speck_pkg::*;

   logic   start;
   block_t key;
   block_t plaintext;
   block_t ciphertext;
   logic   busy;
   logic   finished;

   modport master (
      output start,
      output key,
      output plaintext,
      input  ciphertext,
      input  busy,
      input  finished
   );

   modport slave (
      input  start,
      input  key,
      input  plaintext,
      output ciphertext,
      output busy,
      output finished
   );

endinterface

// File: rtl/speck_round.sv
// One combinational SPECK128/128 round fused with its key-schedule step.
//
// Ports:
//   x, y       - current data words
//   k, l       - current round key and key-schedule word
//   i          - index of the round being executed
//   x_next, y_next - data words after the round
//   k_next, l_next - key-schedule words for round i+1
//
// The key step consumes the same old k that the round uses, so both halves
// see a consistent round key.
module speck_round
   import speck_pkg::*;
(
   input  word_t x,
   input  word_t y,
   input  word_t k,
   input  word_t l,
   input  cnt_t  i,
   output word_t x_next,
   output word_t y_next,
   output word_t k_next,
   output word_t l_next
);

   word_t x_new;
   word_t l_new;

   // Additions wrap modulo 2^64; the carry out is simply dropped.
   always_comb begin
      x_new  = (ror_alpha(x) + y) ^ k;
      l_new  = (ror_alpha(l) + k) ^ word_t'(i);
      x_next = x_new;
      y_next = rol_beta(y) ^ x_new;
      l_next = l_new;
      k_next = rol_beta(k) ^ l_new;
   end

endmodule

// File: rtl/speck_round_sequencer.sv
// Iterative SPECK128/128 encryption controller.
//
// Steps one shared round/key-expansion datapath through all 32 rounds,
// generating round keys on the fly. The requester uses a start/finished
// handshake: start is sampled only in IDLE, busy covers the run, and finished
// pulses for one cycle as the ciphertext register is loaded.
//
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset; discards any in-flight operation
//   bus - speck_round_sequencer_if.slave (start, key, plaintext,
//         ciphertext, busy, finished)
//
// Build option:
//   SPECK_UNROLL2_EN - chain two round instances so rounds 2j and 2j+1 run
//                      on one edge; latency halves, result is unchanged.
module speck_round_sequencer
   import speck_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   speck_round_sequencer_if.slave  bus
);

`ifdef SPECK_UNROLL2_EN
   localparam cnt_t I_STEP = cnt_t'(2);
   localparam cnt_t I_LAST = cnt_t'(ROUNDS - 2);  // pair containing the final round
`else
   localparam cnt_t I_STEP = cnt_t'(1);
   localparam cnt_t I_LAST = cnt_t'(ROUNDS - 1);
`endif

   state_t state_q, state_d;
   cnt_t   i_q, i_d;
   word_t  x_q, x_d;
   word_t  y_q, y_d;
   word_t  k_q, k_d;
   word_t  l_q, l_d;
   block_t ct_q, ct_d;
   logic   busy_q, busy_d;
   logic   fin_q, fin_d;

   // Datapath outputs after this cycle's round(s).
   word_t x_nx, y_nx, k_nx, l_nx;
   word_t x_r0, y_r0, k_r0, l_r0;

   speck_round u_round0 (
      .x      (x_q),
      .y      (y_q),
      .k      (k_q),
      .l      (l_q),
      .i      (i_q),
      .x_next (x_r0),
      .y_next (y_r0),
      .k_next (k_r0),
      .l_next (l_r0)
   );

`ifdef SPECK_UNROLL2_EN
   word_t x_r1, y_r1, k_r1, l_r1;
   cnt_t  i_odd;

   // i_q is always even here, so the second round index never overflows.
   assign i_odd = i_q + cnt_t'(1);

   speck_round u_round1 (
      .x      (x_r0),
      .y      (y_r0),
      .k      (k_r0),
      .l      (l_r0),
      .i      (i_odd),
      .x_next (x_r1),
      .y_next (y_r1),
      .k_next (k_r1),
      .l_next (l_r1)
   );

   assign x_nx = x_r1;
   assign y_nx = y_r1;
   assign k_nx = k_r1;
   assign l_nx = l_r1;
`else
   assign x_nx = x_r0;
   assign y_nx = y_r0;
   assign k_nx = k_r0;
   assign l_nx = l_r0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         l_q     <= '0;
         ct_q    <= '0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         l_q     <= l_d;
         ct_q    <= ct_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      l_d     = l_q;
      ct_d    = ct_q;
      busy_d  = busy_q;
      fin_d   = 1'b0;  // finished is a single-cycle pulse

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               x_d     = bus.plaintext[2*WORD_W-1:WORD_W];
               y_d     = bus.plaintext[WORD_W-1:0];
               l_d     = bus.key[2*WORD_W-1:WORD_W];
               k_d     = bus.key[WORD_W-1:0];
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            x_d = x_nx;
            y_d = y_nx;
            k_d = k_nx;
            l_d = l_nx;
            i_d = i_q + I_STEP;
            if (i_q == I_LAST) begin
               ct_d    = {x_nx, y_nx};
               fin_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end

         DONE: begin
            // start is deliberately not looked at here.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.ciphertext = ct_q;
   assign bus.busy       = busy_q;
   assign bus.finished   = fin_q;

endmodule
